gpio_input_conditioner: RTL

//   Consumes the raw per-bit pad readback (gpio_data_in) of a GPIO bank of gpio_bit cells.
//   Per bit: synchronises to clk, debounces, detects rise/fall edges, latches sticky

---
 rtl/gpio_input_conditioner.sv | 85 ++++++++
 1 files changed

// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioning: synchroniser, debounce, edge detect and sticky
// interrupt status with a single OR-reduced irq line.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_gpio_data_in,
  input  logic [WIDTH-1:0] i_gpio_oen,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_irq_clear,
  output logic [WIDTH-1:0] o_data_clean,
  output logic [WIDTH-1:0] o_irq_status,
  output logic             o_irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_clean_d;
  logic [WIDTH-1:0] r_status;

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= i_gpio_data_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // A sample equal to the current clean level restarts qualification, so only
  // DEBOUNCE_CYCLES consecutive differing samples move the clean level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clean <= '0;
      for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (w_sync_q[b] == r_clean[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_clean[b] <= w_sync_q[b];
          r_cnt[b]   <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  // r_clean_d resets to the same value as r_clean, so leaving reset never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_clean_d <= '0;
    else          r_clean_d <= r_clean;
  end

  assign w_rise = r_clean & ~r_clean_d;
  assign w_fall = ~r_clean & r_clean_d;
  assign w_set  = ((w_rise & i_rise_en) | (w_fall & i_fall_en)) & ~i_gpio_oen;

  // Set has priority over clear so an edge coinciding with a clear is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_status <= '0;
    else          r_status <= w_set | (r_status & ~i_irq_clear);
  end

  assign o_data_clean = r_clean;
  assign o_irq_status = r_status;
  assign o_irq        = |r_status;

endmodule
